// File: rtl/rx_frame_sync.sv
// rx_frame_sync: hunts for the sync word in the demodulated bit stream and
// resolves BPSK polarity. It then deframes a length-prefixed payload into a
// byte stream and checks the trailing XOR checksum.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_HUNT    | shifting raw bits, looking for SYNC_WORD or its inverse
// S_LEN     | collecting the 8-bit length byte
// S_PAYLOAD | collecting payload bytes, one output beat per byte
// S_CHK     | collecting the checksum byte, then pulse ok/err and re-hunt
module rx_frame_sync #(
  parameter logic [15:0] SYNC_WORD = 16'hEB90,
  parameter int          MAX_ERR   = 1
) (
  input  logic       clk_16M384,
  input  logic       rst_16M384,
  input  logic       bit_in,
  input  logic       bit_vld,
  output logic [7:0] data_tdata,
  output logic       data_tvalid,
  output logic       data_tlast,
  output logic       data_tuser,
  output logic       locked,
  output logic       inverted,
  output logic       frame_ok,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK} state_t;

  localparam logic [4:0] L_MAX_ERR = 5'(MAX_ERR);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_sr, w_sr_nxt;
  logic [4:0]  r_hunt_cnt, w_hunt_cnt_nxt;
  logic        r_pol, w_pol_nxt;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_len, w_len_nxt;
  logic [7:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0]  r_chk, w_chk_nxt;
  logic [7:0]  r_tdata, w_tdata_nxt;
  logic        r_tvalid, w_tvalid_nxt;
  logic        r_tlast, w_tlast_nxt;
  logic        r_tuser, w_tuser_nxt;
  logic        r_locked, w_locked_nxt;
  logic        r_inverted, w_inverted_nxt;
  logic        r_ok, w_ok_nxt;
  logic        r_err, w_err_nxt;

  logic        w_bit;
  logic [7:0]  w_byte;
  logic [15:0] w_sr_shift;
  logic [4:0]  w_d0, w_d1;
  logic        w_hunt_full;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  // Datapath helpers shared by all states.
  always_comb begin
    w_bit       = bit_in ^ r_pol;
    w_byte      = {r_shift[6:0], w_bit};
    w_sr_shift  = {r_sr[14:0], bit_in};
    w_d0        = popcount16(w_sr_shift ^ SYNC_WORD);
    w_d1        = popcount16(w_sr_shift ^ ~SYNC_WORD);
    // The window only qualifies once it holds 16 bits seen since entering HUNT.
    w_hunt_full = (r_hunt_cnt >= 5'd15);
  end

  // Next-state and next-output logic; only bit_vld cycles advance anything.
  always_comb begin
    w_state_nxt    = r_state;
    w_sr_nxt       = r_sr;
    w_hunt_cnt_nxt = r_hunt_cnt;
    w_pol_nxt      = r_pol;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_len_nxt      = r_len;
    w_byte_cnt_nxt = r_byte_cnt;
    w_chk_nxt      = r_chk;
    w_tdata_nxt    = r_tdata;
    w_tvalid_nxt   = 1'b0;
    w_tlast_nxt    = 1'b0;
    w_tuser_nxt    = 1'b0;
    w_locked_nxt   = r_locked;
    w_inverted_nxt = r_inverted;
    w_ok_nxt       = 1'b0;
    w_err_nxt      = 1'b0;

    if (bit_vld) begin
      if (r_state == S_HUNT) begin
        w_sr_nxt = w_sr_shift;
        if (r_hunt_cnt != 5'd16) w_hunt_cnt_nxt = r_hunt_cnt + 5'd1;
        if (w_hunt_full) begin
          // A true-polarity match wins over an inverted one.
          if (w_d0 <= L_MAX_ERR) begin
            w_state_nxt    = S_LEN;
            w_pol_nxt      = 1'b0;
            w_inverted_nxt = 1'b0;
            w_locked_nxt   = 1'b1;
            w_bit_cnt_nxt  = 3'd0;
          end else if (w_d1 <= L_MAX_ERR) begin
            w_state_nxt    = S_LEN;
            w_pol_nxt      = 1'b1;
            w_inverted_nxt = 1'b1;
            w_locked_nxt   = 1'b1;
            w_bit_cnt_nxt  = 3'd0;
          end
        end
      end else begin
        w_shift_nxt   = w_byte;
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          case (r_state)
            S_LEN: begin
              w_len_nxt      = w_byte;
              w_chk_nxt      = w_byte;
              w_byte_cnt_nxt = 8'd0;
              w_state_nxt    = (w_byte == 8'd0) ? S_CHK : S_PAYLOAD;
            end
            S_PAYLOAD: begin
              w_chk_nxt      = r_chk ^ w_byte;
              w_byte_cnt_nxt = r_byte_cnt + 8'd1;
              w_tvalid_nxt   = 1'b1;
              w_tdata_nxt    = w_byte;
              w_tuser_nxt    = (r_byte_cnt == 8'd0);
              w_tlast_nxt    = (r_byte_cnt == r_len - 8'd1);
              if (r_byte_cnt == r_len - 8'd1) w_state_nxt = S_CHK;
            end
            S_CHK: begin
              w_ok_nxt       = (w_byte == r_chk);
              w_err_nxt      = (w_byte != r_chk);
              w_locked_nxt   = 1'b0;
              w_state_nxt    = S_HUNT;
              w_sr_nxt       = 16'd0;
              w_hunt_cnt_nxt = 5'd0;
            end
            default: w_state_nxt = S_HUNT;
          endcase
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      r_state    <= S_HUNT;
      r_sr       <= '0;
      r_hunt_cnt <= '0;
      r_pol      <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_chk      <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
      r_locked   <= 1'b0;
      r_inverted <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sr       <= w_sr_nxt;
      r_hunt_cnt <= w_hunt_cnt_nxt;
      r_pol      <= w_pol_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_len      <= w_len_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_chk      <= w_chk_nxt;
      r_tdata    <= w_tdata_nxt;
      r_tvalid   <= w_tvalid_nxt;
      r_tlast    <= w_tlast_nxt;
      r_tuser    <= w_tuser_nxt;
      r_locked   <= w_locked_nxt;
      r_inverted <= w_inverted_nxt;
      r_ok       <= w_ok_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign data_tdata  = r_tdata;
  assign data_tvalid = r_tvalid;
  assign data_tlast  = r_tlast;
  assign data_tuser  = r_tuser;
  assign locked      = r_locked;
  assign inverted    = r_inverted;
  assign frame_ok    = r_ok;
  assign frame_err   = r_err;

endmodule

// File: tb/tb_rx_frame_sync.sv
// tb_rx_frame_sync: directed frames into rx_frame_sync, checking decoded
// beats, tuser/tlast, checksum pulses, polarity and reset behaviour.
module tb_rx_frame_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_vld = 1'b0;
  logic [7:0] data_tdata;
  logic       data_tvalid, data_tlast, data_tuser;
  logic       locked, inverted, frame_ok, frame_err;

  rx_frame_sync dut (
    .clk_16M384 (clk),
    .rst_16M384 (rst),
    .bit_in     (bit_in),
    .bit_vld    (bit_vld),
    .data_tdata (data_tdata),
    .data_tvalid(data_tvalid),
    .data_tlast (data_tlast),
    .data_tuser (data_tuser),
    .locked     (locked),
    .inverted   (inverted),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Receive-side monitor, sampled on the falling edge.
  logic       prev_vld = 1'b0;
  logic [7:0] rx_d[$];
  logic       rx_u[$];
  logic       rx_l[$];
  int         ok_cnt = 0;
  int         err_cnt = 0;
  logic       seen_lock = 1'b0;

  always @(negedge clk) begin
    if (data_tvalid) begin
      rx_d.push_back(data_tdata);
      rx_u.push_back(data_tuser);
      rx_l.push_back(data_tlast);
      check("beat_latency", {15'd0, prev_vld}, 16'd1);
    end
    if (frame_ok) begin
      ok_cnt++;
      check("lock_drop", {15'd0, locked}, 16'd0);
    end
    if (frame_err) err_cnt++;
    if (locked) seen_lock = 1'b1;
    prev_vld = bit_vld;
  end

  logic [7:0] pl[$];

  task automatic clear_rx();
    rx_d.delete();
    rx_u.delete();
    rx_l.delete();
    ok_cnt = 0;
    err_cnt = 0;
    seen_lock = 1'b0;
  endtask

  // One bit per 16 clocks; bit_in toggles randomly while bit_vld is low.
  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_in  = b;
    bit_vld = 1'b1;
    @(posedge clk); #1;
    bit_vld = 1'b0;
    bit_in  = 1'($urandom_range(0, 1));
    repeat (14) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic inv);
    for (int i = 7; i >= 0; i--) send_bit(v[i] ^ inv);
  endtask

  task automatic send_word(input logic [15:0] w, input logic inv);
    for (int i = 15; i >= 0; i--) send_bit(w[i] ^ inv);
  endtask

  // Sync, LEN = pl.size(), payload, then CHK corrupted by chk_mask.
  task automatic send_frame(input logic [15:0] sync, input logic inv, input logic [7:0] chk_mask);
    logic [7:0] c;
    c = 8'(pl.size());
    send_word(sync, inv);
    send_byte(8'(pl.size()), inv);
    foreach (pl[i]) begin
      send_byte(pl[i], inv);
      c = c ^ pl[i];
    end
    send_byte(c ^ chk_mask, inv);
  endtask

  task automatic check_frame(input string tag, input int exp_ok, input int exp_err, input logic exp_inv);
    check({tag, "_nbeats"}, 16'(rx_d.size()), 16'(pl.size()));
    if (rx_d.size() == pl.size()) begin
      foreach (pl[i]) begin
        check({tag, "_tdata"}, {8'd0, rx_d[i]}, {8'd0, pl[i]});
        check({tag, "_tuser"}, {15'd0, rx_u[i]}, {15'd0, (i == 0)});
        check({tag, "_tlast"}, {15'd0, rx_l[i]}, {15'd0, (i == pl.size() - 1)});
      end
    end
    check({tag, "_ok"}, 16'(ok_cnt), 16'(exp_ok));
    check({tag, "_err"}, 16'(err_cnt), 16'(exp_err));
    check({tag, "_inverted"}, {15'd0, inverted}, {15'd0, exp_inv});
    check({tag, "_locked_end"}, {15'd0, locked}, 16'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {data_tdata, data_tvalid, data_tlast, data_tuser, locked, inverted, frame_ok, frame_err, 1'b0},
          16'd0);
    rst = 1'b0;

    // Clean frame, true polarity.
    clear_rx();
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(16'hEB90, 1'b0, 8'h00);
    check_frame("clean", 1, 0, 1'b0);

    // Same frame, every bit inverted on air.
    clear_rx();
    send_frame(16'hEB90, 1'b1, 8'h00);
    check_frame("inverted", 1, 0, 1'b1);

    // Two sync errors: no lock, no output.
    clear_rx();
    send_word(16'hEB93, 1'b0);
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    check("sync2err_lock", {15'd0, seen_lock}, 16'd0);
    check("sync2err_beats", 16'(rx_d.size()), 16'd0);

    // One sync error: accepted.
    clear_rx();
    send_frame(16'hEB91, 1'b0, 8'h00);
    check_frame("sync1err", 1, 0, 1'b0);

    // Empty payload.
    clear_rx();
    pl.delete();
    send_frame(16'hEB90, 1'b0, 8'h00);
    check_frame("len0", 1, 0, 1'b0);

    // Single byte: tuser and tlast on the same beat, CHK = AB.
    clear_rx();
    pl = '{8'hAA};
    send_frame(16'hEB90, 1'b0, 8'h00);
    check_frame("len1", 1, 0, 1'b0);

    // CHK = AC instead of AB: byte still delivered, frame_err.
    clear_rx();
    send_frame(16'hEB90, 1'b0, 8'h07);
    check_frame("badchk", 0, 1, 1'b0);

    // Leading noise, then back-to-back frames.
    clear_rx();
    for (int i = 0; i < 12; i++) send_bit(1'b0);
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(16'hEB90, 1'b0, 8'h00);
    check_frame("b2b_first", 1, 0, 1'b0);
    clear_rx();
    pl = '{8'hA5, 8'h5A};
    send_frame(16'hEB90, 1'b0, 8'h00);
    check_frame("b2b_second", 1, 0, 1'b0);

    // Reset after the second payload byte.
    clear_rx();
    send_word(16'hEB90, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("prereset_beats", 16'(rx_d.size()), 16'd2);
    check("prereset_locked", {15'd0, locked}, 16'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_outputs",
          {data_tdata, data_tvalid, data_tlast, data_tuser, locked, inverted, frame_ok, frame_err, 1'b0},
          16'd0);
    clear_rx();
    pl = '{8'h44, 8'h55, 8'h66};
    send_frame(16'hEB90, 1'b0, 8'h00);
    check_frame("postreset", 1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
